db9md_pad_emu: RTL and testbench

DB9MD_PAD_EMU -- requirements
Module: db9md_pad_emu

---
 rtl/db9md_pad_emu.sv | 123 ++++++++++++
 tb/tb_db9md_pad_emu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/db9md_pad_emu.sv
// Sega DB9 3/6-button pad emulator; DB9MD_SIX_BUTTON_EN enables the 6-button phase sequencing.
// joy_out registered: 3 clk from joy_sel, 1 clk from buttons; no backpressure (console polls freely).
module db9md_pad_emu #(
   parameter int unsigned TIMEOUT_CYCLES = 75000
) (
   input  logic        CLK_50,
   input  logic        RESET,
   input  logic        joy_sel,
   input  logic [11:0] buttons,
   output logic [5:0]  joy_out,
   output logic [1:0]  phase
);

   localparam int unsigned BTN_R     = 0;
   localparam int unsigned BTN_L     = 1;
   localparam int unsigned BTN_D     = 2;
   localparam int unsigned BTN_U     = 3;
   localparam int unsigned BTN_A     = 4;
   localparam int unsigned BTN_B     = 5;
   localparam int unsigned BTN_C     = 6;
   localparam int unsigned BTN_START = 10;

   logic       r_sync1;
   logic       r_sel_s;
   logic [5:0] r_joy;
   logic [5:0] w_joy_nxt;
   logic [1:0] w_phase;

   // SEL idles high, so reset the synchroniser high to avoid a false first edge.
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         r_sync1 <= 1'b1;
         r_sel_s <= 1'b1;
      end else begin
         r_sync1 <= joy_sel;
         r_sel_s <= r_sync1;
      end
   end

`ifdef DB9MD_SIX_BUTTON_EN
   localparam int unsigned BTN_X    = 7;
   localparam int unsigned BTN_Y    = 8;
   localparam int unsigned BTN_Z    = 9;
   localparam int unsigned BTN_MODE = 11;

   localparam int unsigned        IDLE_W   = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

   logic              r_sel_prev;
   logic [1:0]        r_phase;
   logic [IDLE_W-1:0] r_idle;
   logic              w_rise;

   assign w_rise = r_sel_s & ~r_sel_prev;

   // A rising edge takes priority over the timeout on the same cycle.
   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         r_sel_prev <= 1'b1;
         r_phase    <= 2'd0;
         r_idle     <= '0;
      end else begin
         r_sel_prev <= r_sel_s;
         if (w_rise) begin
            r_phase <= r_phase + 2'd1;
            r_idle  <= '0;
         end else if (r_idle == IDLE_MAX) begin
            r_phase <= 2'd0;
         end else begin
            r_idle <= r_idle + IDLE_W'(1);
         end
      end
   end

   assign w_phase = r_phase;

   always_comb begin
      w_joy_nxt = 6'b111111;
      if (r_sel_s) begin
         if (w_phase == 2'd3)
            w_joy_nxt = {~buttons[BTN_C], ~buttons[BTN_B], ~buttons[BTN_Z],
                         ~buttons[BTN_Y], ~buttons[BTN_X], ~buttons[BTN_MODE]};
         else
            w_joy_nxt = {~buttons[BTN_C], ~buttons[BTN_B], ~buttons[BTN_U],
                         ~buttons[BTN_D], ~buttons[BTN_L], ~buttons[BTN_R]};
      end else begin
         case (w_phase)
            2'd2:    w_joy_nxt = {~buttons[BTN_START], ~buttons[BTN_A], 4'b0000};
            2'd3:    w_joy_nxt = {~buttons[BTN_START], ~buttons[BTN_A], 4'b1111};
            default: w_joy_nxt = {~buttons[BTN_START], ~buttons[BTN_A],
                                  ~buttons[BTN_U], ~buttons[BTN_D], 2'b00};
         endcase
      end
   end
`else
   logic w_unused_xyzm;

   // X/Y/Z/Mode have no meaning on a 3-button pad.
   assign w_unused_xyzm = ^{buttons[11], buttons[9:7]};
   assign w_phase       = 2'd0;

   always_comb begin
      w_joy_nxt = 6'b111111;
      if (r_sel_s)
         w_joy_nxt = {~buttons[BTN_C], ~buttons[BTN_B], ~buttons[BTN_U],
                      ~buttons[BTN_D], ~buttons[BTN_L], ~buttons[BTN_R]};
      else
         w_joy_nxt = {~buttons[BTN_START], ~buttons[BTN_A],
                      ~buttons[BTN_U], ~buttons[BTN_D], 2'b00};
   end
`endif

   always_ff @(posedge CLK_50) begin
      if (RESET)
         r_joy <= 6'b111111;
      else
         r_joy <= w_joy_nxt;
   end

   assign joy_out = r_joy;
   assign phase   = w_phase;

endmodule

// File: tb/tb_db9md_pad_emu.sv
// Bench for db9md_pad_emu: vector table, directed SEL sequences and random stimulus vs a cycle reference.
module tb_db9md_pad_emu;

   localparam int T = 60;

   logic        CLK_50 = 1'b0;
   logic        RESET;
   logic        joy_sel;
   logic [11:0] buttons;
   wire  [5:0]  joy_out;
   wire  [1:0]  phase;

   db9md_pad_emu #(.TIMEOUT_CYCLES(T)) dut (
      .CLK_50  (CLK_50),
      .RESET   (RESET),
      .joy_sel (joy_sel),
      .buttons (buttons),
      .joy_out (joy_out),
      .phase   (phase)
   );

   always #10 CLK_50 = ~CLK_50;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Pad word as seen by the console for a given SEL level, phase and button set.
   function automatic logic [5:0] pad_word(input bit sel, input int ph, input logic [11:0] b);
      bit rt = b[0], lf = b[1], dn = b[2], up = b[3], a = b[4], bb = b[5];
      bit c = b[6], x = b[7], y = b[8], z = b[9], st = b[10], md = b[11];
      if (sel) begin
         if (ph == 3) return ~{c, bb, z, y, x, md};
         return ~{c, bb, up, dn, lf, rt};
      end
      if (ph == 2) return {~st, ~a, 4'b0000};
      if (ph == 3) return {~st, ~a, 4'b1111};
      return {~st, ~a, ~up, ~dn, 2'b00};
   endfunction

   // Reference: sel_s lags the pin by two samples; phase counts edges mod 4 and
   // is cleared once more than T edges have passed since the last SEL rise or reset.
   int unsigned m_edge  = 0;
   int unsigned m_last  = 0;
   bit [2:0]    m_hist  = 3'b111;
   int          m_phase = 0;
   logic [5:0]  m_joy   = 6'b111111;
   bit          m_valid = 1'b0;

   always @(posedge CLK_50) begin
      m_edge++;
      if (RESET) begin
         m_hist  = 3'b111;
         m_phase = 0;
         m_joy   = 6'b111111;
         m_last  = m_edge;
         m_valid = 1'b1;
      end else begin
         m_joy = pad_word(m_hist[1], m_phase, buttons);
`ifdef DB9MD_SIX_BUTTON_EN
         if (m_hist[1] && !m_hist[2]) begin
            m_phase = (m_phase + 1) % 4;
            m_last  = m_edge;
         end else if (m_edge - 1 - m_last >= T) begin
            m_phase = 0;
         end
`endif
         m_hist = {m_hist[1:0], joy_sel};
      end
   end

   always @(negedge CLK_50) begin
      if (m_valid) begin
         check("model joy_out", joy_out, m_joy);
         check("model phase", {4'b0000, phase}, 6'(m_phase));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge CLK_50);
   endtask

   task automatic do_reset();
      RESET   = 1'b1;
      joy_sel = 1'b1;
      step(2);
      RESET   = 1'b0;
   endtask

   task automatic pulse(input int lo, input int hi);
      joy_sel = 1'b0;
      step(lo);
      joy_sel = 1'b1;
      step(hi);
   endtask

   typedef struct {
      bit          sel;
      logic [11:0] btn;
      logic [5:0]  exp;
      string       name;
   } vec_t;

   vec_t vecs[12];

`ifdef DB9MD_SIX_BUTTON_EN
   int wrap_exp[5] = '{1, 2, 3, 0, 1};
   int coll_exp[3] = '{2, 2, 1};
`endif

   initial begin
      vecs[0]  = '{1'b1, 12'h011, 6'b111110, "hi A+R"};
      vecs[1]  = '{1'b0, 12'h011, 6'b101100, "lo A+R"};
      vecs[2]  = '{1'b1, 12'h00C, 6'b110011, "hi U+D"};
      vecs[3]  = '{1'b1, 12'h003, 6'b111100, "hi L+R"};
      vecs[4]  = '{1'b0, 12'h00C, 6'b110000, "lo U+D"};
      vecs[5]  = '{1'b0, 12'h400, 6'b011100, "lo Start"};
      vecs[6]  = '{1'b1, 12'h060, 6'b001111, "hi B+C"};
      vecs[7]  = '{1'b1, 12'h380, 6'b111111, "hi XYZ ph0"};
      vecs[8]  = '{1'b0, 12'hFFF, 6'b000000, "lo all"};
      vecs[9]  = '{1'b1, 12'hFFF, 6'b000000, "hi all"};
      vecs[10] = '{1'b0, 12'h000, 6'b111100, "lo none"};
      vecs[11] = '{1'b1, 12'h000, 6'b111111, "hi none"};

      RESET   = 1'b1;
      joy_sel = 1'b1;
      buttons = 12'hFFF;
      step(2);
      check("reset joy_out", joy_out, 6'b111111);
      check("reset phase", {4'b0000, phase}, 6'd0);
      RESET = 1'b0;

      for (int i = 0; i < 12; i++) begin
         do_reset();
         joy_sel = vecs[i].sel;
         buttons = vecs[i].btn;
         step(4);
         check(vecs[i].name, joy_out, vecs[i].exp);
      end

      // SEL-to-output latency and button-to-output latency
      do_reset();
      buttons = 12'h011;
      step(4);
      check("3btn hi A+R", joy_out, 6'b111110);
      joy_sel = 1'b0;
      step(2);
      check("sel latency 2clk", joy_out, 6'b111110);
      step(1);
      check("sel latency 3clk", joy_out, 6'b101100);
      buttons = 12'h001;
      step(1);
      check("button latency 1clk", joy_out, 6'b111100);

`ifdef DB9MD_SIX_BUTTON_EN
      do_reset();
      buttons = 12'h880;
      step(30);
      check("sel held high no edge", {4'b0000, phase}, 6'd0);
      pulse(20, 20);
      pulse(20, 20);
      joy_sel = 1'b0;
      step(20);
      check("third low ident", joy_out, 6'b110000);
      joy_sel = 1'b1;
      step(20);
      check("third high XYZM", joy_out, 6'b111100);
      check("third high phase", {4'b0000, phase}, 6'd3);
      joy_sel = 1'b0;
      step(20);
      check("fourth low", joy_out, 6'b111111);
      joy_sel = 1'b1;
      step(20);
      check("fourth high phase", {4'b0000, phase}, 6'd0);

      do_reset();
      buttons = 12'h408;
      pulse(20, 20);
      pulse(20, 20);
      check("pre-timeout phase", {4'b0000, phase}, 6'd2);
      step(T + 5);
      check("timeout phase", {4'b0000, phase}, 6'd0);
      joy_sel = 1'b0;
      step(20);
      check("after timeout low", joy_out, 6'b010100);

      do_reset();
      for (int k = 0; k < 5; k++) begin
         pulse(20, 20);
         check("wrap phase", {4'b0000, phase}, 6'(wrap_exp[k]));
      end

      // second rise lands one before, exactly on, and one after the timeout cycle
      for (int d = 0; d < 3; d++) begin
         do_reset();
         pulse(1, T - 1 + d);
         joy_sel = 1'b0;
         step(1);
         joy_sel = 1'b1;
         step(4);
         check("edge/timeout collision", {4'b0000, phase}, 6'(coll_exp[d]));
      end

      do_reset();
      buttons = 12'h408;
      pulse(20, 20);
      pulse(20, 20);
      pulse(20, 10);
      do_reset();
      check("mid-seq reset phase", {4'b0000, phase}, 6'd0);
      joy_sel = 1'b0;
      step(20);
      check("mid-seq reset low", joy_out, 6'b010100);
`else
      do_reset();
      buttons = 12'h880;
      for (int k = 0; k < 4; k++) begin
         pulse(20, 20);
         check("3btn high ignores XYZM", joy_out, 6'b111111);
         check("3btn phase stays 0", {4'b0000, phase}, 6'd0);
      end
      joy_sel = 1'b0;
      step(20);
      check("3btn low no ident", joy_out, 6'b111100);
`endif

      do_reset();
      for (int i = 0; i < 400; i++) begin
         int dur;
         if ($urandom_range(0, 39) == 0) begin
            RESET = 1'b1;
            step($urandom_range(1, 3));
            RESET = 1'b0;
         end
         buttons = 12'($urandom);
         joy_sel = ~joy_sel;
         if ($urandom_range(0, 7) == 0) dur = $urandom_range(T - 3, T + 8);
         else dur = $urandom_range(1, 25);
         step(dur);
      end

      step(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
